// File: rtl/ram_dp_fill_pkg.sv
// Shared definitions for the dual-port RAM with built-in fill engine:
// read-during-write mode constants and the fill-sequencer state encoding.
package ram_dp_fill_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/ram_fill_seq.sv
// Fill sequencer: on a start it sweeps every address once, presenting a
// write of the captured fill value per cycle for the top to mux onto port A.
module ram_fill_seq
  import ram_dp_fill_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fill,
  input  logic [DW-1:0] fv,
  output logic          busy,
  output logic [AW-1:0] fill_addr,
  output logic [DW-1:0] fill_data,
  output logic          fill_we
);

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW-1:0] ONE_ADDR  = {{(AW-1){1'b0}}, 1'b1};

  fill_state_t   state_r, state_next_s;
  logic [AW-1:0] count_r, count_next_s;
  logic [DW-1:0] value_r, value_next_s;

  // State, sweep counter and captured fill value
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= '0;
      value_r <= '0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      value_r <= value_next_s;
    end
  end

  // Next-state logic; fill is ignored while a sweep runs
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    value_next_s = value_r;
    case (state_r)
      ST_IDLE: begin
        if (fill) begin
          value_next_s = fv;
          count_next_s = '0;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_r == LAST_ADDR) begin
          count_next_s = '0;
          state_next_s = ST_IDLE;
        end else begin
          count_next_s = count_r + ONE_ADDR;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        count_next_s = '0;
      end
    endcase
  end

  // An aborting reset must not let the in-flight location be written
  assign busy      = (state_r == ST_RUN);
  assign fill_we   = busy & ~reset;
  assign fill_addr = count_r;
  assign fill_data = value_r;

endmodule

// File: rtl/ram_dp_fill.sv
// True dual-port synchronous RAM with registered outputs and a fill engine
// that shares port A's write path to clear memory after a machine reset.
module ram_dp_fill
  import ram_dp_fill_pkg::*;
#(
  parameter int    AW  = 14,
  parameter int    DW  = 8,
  parameter string FN  = "",
  parameter int    RDW = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cea,
  input  logic          wea,
  input  logic [AW-1:0] aa,
  input  logic [DW-1:0] da,
  output logic [DW-1:0] qa,
  input  logic          ceb,
  input  logic          web,
  input  logic [AW-1:0] ab,
  input  logic [DW-1:0] db,
  output logic [DW-1:0] qb,
  input  logic          fill,
  input  logic [DW-1:0] fv,
  output logic          busy
);

  localparam bit NEW_DATA = (RDW != RDW_OLD);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          fill_we;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          cpu_wr_a;
  logic          wr_a;
  logic [AW-1:0] wr_addr_a;
  logic [DW-1:0] wr_data_a;
  logic          req_wr_b;
  logic          wr_b;

  ram_fill_seq #(.AW(AW), .DW(DW)) u_seq (
    .clock     (clock),
    .reset     (reset),
    .fill      (fill),
    .fv        (fv),
    .busy      (busy),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .fill_we   (fill_we)
  );

  // The engine owns port A's write path for the whole sweep
  assign cpu_wr_a  = cea & ~wea & ~busy;
  assign wr_a      = fill_we | cpu_wr_a;
  assign wr_addr_a = fill_we ? fill_addr : aa;
  assign wr_data_a = fill_we ? fill_data : da;
  assign req_wr_b  = ceb & ~web;
  assign wr_b      = req_wr_b & ~(wr_a & (wr_addr_a == ab));

  // Memory array writes; a port A (or engine) write to the same word wins
  always_ff @(posedge clock) begin
    if (wr_b) mem[ab] <= db;
    if (wr_a) mem[wr_addr_a] <= wr_data_a;
  end

  // Port A registered read
  always_ff @(posedge clock) begin
    if (reset) begin
      qa <= '0;
    end else if (cea) begin
      if (NEW_DATA && cpu_wr_a) qa <= da;
      else                      qa <= mem[aa];
    end
  end

  // Port B registered read
  always_ff @(posedge clock) begin
    if (reset) begin
      qb <= '0;
    end else if (ceb) begin
      if (NEW_DATA && req_wr_b) qb <= db;
      else                      qb <= mem[ab];
    end
  end

endmodule
